// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop line synchroniser, mid-bit sampling, framing check,
// and a single-entry valid/ready holding register with overrun and frame-error pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_WAIT  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic [1:0]       sync_q;

  logic rx_s;
  logic half_hit_s;
  logic full_hit_s;
  logic stop_smp_s;
  logic drain_s;

  assign rx_s       = sync_q[1];
  assign half_hit_s = (cnt_q == HALF_M1);
  assign full_hit_s = (cnt_q == FULL_M1);
  assign stop_smp_s = (state_q == S_STOP) && full_hit_s;
  assign drain_s    = valid_q && data_ready;

  // State register plus all datapath registers; synchroniser resets to the idle-high level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic; the counter is cleared on every transition and every sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (half_hit_s) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (full_hit_s) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (full_hit_s) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = 3'd0;
      end
    endcase
  end

  // Datapath and output next values: shifting, holding-register load/drain, pulses.
  always_comb begin
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q && !data_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    if ((state_q == S_DATA) && full_hit_s) begin
      shift_d = {rx_s, shift_q[7:1]};
    end else begin
      shift_d = shift_q;
    end
    if (stop_smp_s && rx_s) begin
      if (!valid_q || drain_s) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (stop_smp_s) begin
      ferr_d = 1'b1;
    end else begin
      ferr_d = 1'b0;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
